key_debounce_array: RTL and testbench

Parametrised multi-channel push-button conditioner. It replaces single-key debouncing for the 2048 game's input panel. Each of N_KEYS raw, asynchronous button inputs is synchronised and debounced independently, then reported as a debounced level plus single-cycle press and release pulses. The block also produces a long-press pulse and optional auto-repeat pulses, so the game controller can implement held-direction moves without its own timers.

---
 rtl/key_debounce_array.sv | 168 ++++++++++++++++
 tb/tb_key_debounce_array.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/key_debounce_array.sv
// Multi-channel push-button conditioner: per-key synchroniser and debounce filter
// producing a debounced level plus press/release/long-press/auto-repeat pulses.
module key_debounce_array #(
  parameter int N_KEYS       = 4,
  parameter int DEBOUNCE_CYC = 1_000_000,
  parameter int LONG_CYC     = 50_000_000,
  parameter int REPEAT_CYC   = 10_000_000,
  parameter bit ACTIVE_HIGH  = 1'b1
) (
  input  logic              i_clk,
  input  logic              i_rstn,
  input  logic [N_KEYS-1:0] i_key,
  input  logic              i_repeat_en,
  output logic [N_KEYS-1:0] o_key_state,
  output logic [N_KEYS-1:0] o_press,
  output logic [N_KEYS-1:0] o_release,
  output logic [N_KEYS-1:0] o_long,
  output logic [N_KEYS-1:0] o_repeat
);

  localparam int MAX_DL  = (DEBOUNCE_CYC > LONG_CYC) ? DEBOUNCE_CYC : LONG_CYC;
  localparam int MAX_CYC = (MAX_DL > REPEAT_CYC) ? MAX_DL : REPEAT_CYC;
  localparam int CNT_W   = ($clog2(MAX_CYC) < 1) ? 1 : $clog2(MAX_CYC);

  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYC - 1);
  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYC - 1);
  localparam logic [CNT_W-1:0] RPT_LAST  = CNT_W'(REPEAT_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  // Synchroniser resets to the released level so reset never looks like a press.
  localparam logic [N_KEYS-1:0] REL_LVL = ACTIVE_HIGH ? {N_KEYS{1'b0}} : {N_KEYS{1'b1}};

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_FILT_DN = 2'd1,
    ST_DOWN    = 2'd2,
    ST_FILT_UP = 2'd3
  } state_t;

  logic [N_KEYS-1:0] sync1_q;
  logic [N_KEYS-1:0] sync2_q;
  logic [N_KEYS-1:0] pressed;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      sync1_q <= REL_LVL;
      sync2_q <= REL_LVL;
    end else begin
      sync1_q <= i_key;
      sync2_q <= sync1_q;
    end
  end

  assign pressed = ACTIVE_HIGH ? sync2_q : ~sync2_q;

  for (genvar gi = 0; gi < N_KEYS; gi++) begin : g_ch
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             long_done_q, long_done_d;
    logic             key_state_q, key_state_d;
    logic             press_q, press_d;
    logic             release_q, release_d;
    logic             long_q, long_d;
    logic             repeat_q, repeat_d;

    always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
        state_q     <= ST_IDLE;
        cnt_q       <= '0;
        long_done_q <= 1'b0;
        key_state_q <= 1'b0;
        press_q     <= 1'b0;
        release_q   <= 1'b0;
        long_q      <= 1'b0;
        repeat_q    <= 1'b0;
      end else begin
        state_q     <= state_d;
        cnt_q       <= cnt_d;
        long_done_q <= long_done_d;
        key_state_q <= key_state_d;
        press_q     <= press_d;
        release_q   <= release_d;
        long_q      <= long_d;
        repeat_q    <= repeat_d;
      end
    end

    always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      long_done_d = long_done_q;
      press_d     = 1'b0;
      release_d   = 1'b0;
      long_d      = 1'b0;
      repeat_d    = 1'b0;

      unique case (state_q)
        ST_IDLE: begin
          cnt_d       = '0;
          long_done_d = 1'b0;
          if (pressed[gi]) state_d = ST_FILT_DN;
        end

        ST_FILT_DN: begin
          if (!pressed[gi]) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end else if (cnt_q == DEB_LAST) begin
            state_d = ST_DOWN;
            cnt_d   = '0;
            press_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end

        ST_DOWN: begin
          if (!pressed[gi]) begin
            state_d = ST_FILT_UP;
            cnt_d   = '0;
          end else if (!long_done_q && cnt_q == LONG_LAST) begin
            long_d      = 1'b1;
            long_done_d = 1'b1;
            cnt_d       = '0;
          end else if (long_done_q && i_repeat_en && cnt_q == RPT_LAST) begin
            repeat_d = 1'b1;
            cnt_d    = '0;
          end else if (long_done_q && !i_repeat_en) begin
            // Parked at 0 so re-enabling waits a full repeat period.
            cnt_d = '0;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end

        ST_FILT_UP: begin
          if (pressed[gi]) begin
            // Bounce back to held: keep long_done so o_long stays once-per-press.
            state_d = ST_DOWN;
            cnt_d   = '0;
          end else if (cnt_q == DEB_LAST) begin
            state_d     = ST_IDLE;
            cnt_d       = '0;
            long_done_d = 1'b0;
            release_d   = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end

        default: begin
          state_d     = ST_IDLE;
          cnt_d       = '0;
          long_done_d = 1'b0;
        end
      endcase

      key_state_d = (state_d == ST_DOWN) || (state_d == ST_FILT_UP);
    end

    assign o_key_state[gi] = key_state_q;
    assign o_press[gi]     = press_q;
    assign o_release[gi]   = release_q;
    assign o_long[gi]      = long_q;
    assign o_repeat[gi]    = repeat_q;
  end

endmodule

// File: tb/tb_key_debounce_array.sv
// Scoreboard bench for key_debounce_array: expected pulses are queued with their
// due edge when stimulus is driven and compared every cycle against both instances.
module tb_key_debounce_array;

  localparam int DEB = 8;
  localparam int LNG = 32;
  localparam int RPT = 16;
  localparam int LAT = DEB + 3;  // drive-to-output edges (2 sync flops + IDLE->FILT_DN)

  localparam int K_PRESS = 0, K_REL = 1, K_LONG = 2, K_RPT = 3;
  localparam int K_LO_PRESS = 4, K_LO_REL = 5;

  typedef struct {
    int         cyc;
    int         kind;
    logic [3:0] mask;
  } sb_item_t;

  logic       clk = 1'b0;
  logic       rstn;
  logic [3:0] key;
  logic [3:0] key_lo;
  logic       rep_en;

  logic [3:0] ks, prs, rel, lng, rpt;
  logic [3:0] ks_lo, prs_lo, rel_lo, lng_lo, rpt_lo;

  sb_item_t   sb_q[$];
  int         edge_n = 0;
  int         n_checks = 0;
  int         n_errors = 0;
  logic [3:0] ks_exp = '0;
  logic [3:0] ks_lo_exp = '0;
  logic [3:0] exp_v [8];

  always #5 clk = ~clk;
  always @(posedge clk) edge_n <= edge_n + 1;

  key_debounce_array #(
    .N_KEYS(4), .DEBOUNCE_CYC(DEB), .LONG_CYC(LNG), .REPEAT_CYC(RPT), .ACTIVE_HIGH(1'b1)
  ) dut (
    .i_clk(clk), .i_rstn(rstn), .i_key(key), .i_repeat_en(rep_en),
    .o_key_state(ks), .o_press(prs), .o_release(rel), .o_long(lng), .o_repeat(rpt)
  );

  key_debounce_array #(
    .N_KEYS(4), .DEBOUNCE_CYC(DEB), .LONG_CYC(LNG), .REPEAT_CYC(RPT), .ACTIVE_HIGH(1'b0)
  ) dut_lo (
    .i_clk(clk), .i_rstn(rstn), .i_key(key_lo), .i_repeat_en(rep_en),
    .o_key_state(ks_lo), .o_press(prs_lo), .o_release(rel_lo), .o_long(lng_lo), .o_repeat(rpt_lo)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h (edge %0d)", tag, obs, exp, edge_n);
    end
  endtask

  task automatic push(input int cyc, input int kind, input logic [3:0] mask);
    sb_item_t it;
    it.cyc  = cyc;
    it.kind = kind;
    it.mask = mask;
    sb_q.push_back(it);
  endtask

  // Inputs change 2 time units after the falling edge, clear of the monitor.
  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      #2;
    end
  endtask

  // Monitor: pop everything due at this edge, then compare all outputs.
  always @(negedge clk) begin
    for (int k = 0; k < 8; k++) exp_v[k] = '0;
    for (int i = sb_q.size() - 1; i >= 0; i--) begin
      if (sb_q[i].cyc == edge_n) begin
        exp_v[sb_q[i].kind] = exp_v[sb_q[i].kind] | sb_q[i].mask;
        $display("edge %0d: expect kind %0d mask %b", edge_n, sb_q[i].kind, sb_q[i].mask);
        sb_q.delete(i);
      end
    end
    if (!rstn) begin
      ks_exp    = '0;
      ks_lo_exp = '0;
    end else begin
      ks_exp    = (ks_exp | exp_v[K_PRESS]) & ~exp_v[K_REL];
      ks_lo_exp = (ks_lo_exp | exp_v[K_LO_PRESS]) & ~exp_v[K_LO_REL];
    end
    check_eq("press",      32'(prs),    32'(exp_v[K_PRESS]));
    check_eq("release",    32'(rel),    32'(exp_v[K_REL]));
    check_eq("long",       32'(lng),    32'(exp_v[K_LONG]));
    check_eq("repeat",     32'(rpt),    32'(exp_v[K_RPT]));
    check_eq("key_state",  32'(ks),     32'(ks_exp));
    check_eq("lo_press",   32'(prs_lo), 32'(exp_v[K_LO_PRESS]));
    check_eq("lo_release", 32'(rel_lo), 32'(exp_v[K_LO_REL]));
    check_eq("lo_long",    32'(lng_lo), 32'h0);
    check_eq("lo_repeat",  32'(rpt_lo), 32'h0);
    check_eq("lo_state",   32'(ks_lo),  32'(ks_lo_exp));
  end

  initial begin
    int e;
    int p;
    rstn   = 1'b0;
    key    = 4'b0000;
    key_lo = 4'b1111;
    rep_en = 1'b0;
    step(1);
    check_eq("rst_main", 32'({ks, prs, rel, lng, rpt}), 32'h0);
    check_eq("rst_lo", 32'({ks_lo, prs_lo, rel_lo, lng_lo, rpt_lo}), 32'h0);
    step(3);
    rstn = 1'b1;
    step(100);

    // Active-low instance: press and release key0.
    e = edge_n; key_lo[0] = 1'b0; push(e + LAT, K_LO_PRESS, 4'b0001);
    step(20);
    e = edge_n; key_lo[0] = 1'b1; push(e + LAT, K_LO_REL, 4'b0001);
    step(15);

    // Clean press on key0 with long press, no repeat.
    e = edge_n; key[0] = 1'b1;
    push(e + LAT, K_PRESS, 4'b0001);
    push(e + LAT + LNG, K_LONG, 4'b0001);
    step(60);
    e = edge_n; key[0] = 1'b0; push(e + LAT, K_REL, 4'b0001);
    step(15);

    // Bouncing key1, then settle high.
    for (int i = 0; i < 10; i++) begin
      key[1] = (i % 2 == 0);
      step(3);
    end
    e = edge_n; key[1] = 1'b1; push(e + LAT, K_PRESS, 4'b0010);
    step(20);
    e = edge_n; key[1] = 1'b0; push(e + LAT, K_REL, 4'b0010);
    step(15);

    // Short glitch on key2: nothing expected.
    key[2] = 1'b1;
    step(5);
    key[2] = 1'b0;
    step(20);

    // Auto-repeat on key3, disable at +70, re-enable at +85.
    rep_en = 1'b1;
    e = edge_n; key[3] = 1'b1; p = e + LAT;
    push(p, K_PRESS, 4'b1000);
    push(p + LNG, K_LONG, 4'b1000);
    push(p + LNG + RPT, K_RPT, 4'b1000);
    push(p + LNG + 2 * RPT, K_RPT, 4'b1000);
    step(p + 69 - edge_n);
    rep_en = 1'b0;
    step(p + 84 - edge_n);
    rep_en = 1'b1;
    push(p + 84 + RPT, K_RPT, 4'b1000);
    step(p + 100 - edge_n);
    e = edge_n; key[3] = 1'b0; push(e + LAT, K_REL, 4'b1000);
    step(15);
    rep_en = 1'b0;
    step(5);

    // Simultaneous press on keys 0 and 2, then a release bounce on key0.
    e = edge_n; key[0] = 1'b1; key[2] = 1'b1;
    push(e + LAT, K_PRESS, 4'b0101);
    push(e + LAT + LNG, K_LONG, 4'b0101);
    step(50);
    key[0] = 1'b0;
    step(4);
    key[0] = 1'b1;
    step(40);
    e = edge_n; key[0] = 1'b0; key[2] = 1'b0;
    push(e + LAT, K_REL, 4'b0101);
    step(15);

    // Reset while key0 is held down.
    e = edge_n; key[0] = 1'b1;
    push(e + LAT, K_PRESS, 4'b0001);
    step(20);
    rstn = 1'b0;
    sb_q.delete();
    #1;
    check_eq("rst_async", 32'({ks, prs, rel, lng, rpt}), 32'h0);
    step(3);
    e = edge_n; rstn = 1'b1; push(e + LAT, K_PRESS, 4'b0001);
    step(20);
    e = edge_n; key[0] = 1'b0; push(e + LAT, K_REL, 4'b0001);
    step(20);

    check_eq("sb_empty", 32'(sb_q.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
